// File: rtl/fdc_error_event_decoder.sv
// ---------------------------------------------------------------------------
// fdc_error_event_decoder
//
// Turns the uPD765-style result bytes (ST0/ST1/ST2) of each FDC command, plus
// the live PLL-lock and drive write-fault lines, into one-cycle error strobes
// and an operation_complete pulse for the lifetime error counter bank. It
// also owns the seek timeout. Each error class fires at most once per
// operation.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   cmd_start           pulse, command begins; qualified by cmd_is_seek and
//                       cmd_is_write
//   cmd_done            pulse, result phase; st0/st1/st2 valid this cycle
//   st0, st1, st2       result status bytes
//   seek_complete       pulse, head reached the target track
//   pll_locked          level, data separator lock
//   drive_fault         level, drive write-fault line
//   err_*               one-cycle error strobes (all registered)
//   operation_complete  one-cycle pulse per finished read/write command
//   op_aborted          one-cycle pulse when a new command pre-empts an old one
//   busy                high in every state except IDLE
// ---------------------------------------------------------------------------
module fdc_error_event_decoder #(
    parameter int unsigned SEEK_TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TMR_W               = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic       cmd_is_seek,
    input  logic       cmd_is_write,
    input  logic       cmd_done,
    input  logic [7:0] st0,
    input  logic [7:0] st1,
    input  logic [7:0] st2,
    input  logic       seek_complete,
    input  logic       pll_locked,
    input  logic       drive_fault,
    output logic       err_crc_data,
    output logic       err_crc_addr,
    output logic       err_missing_am,
    output logic       err_missing_dam,
    output logic       err_overrun,
    output logic       err_underrun,
    output logic       err_seek,
    output logic       err_write_fault,
    output logic       err_pll_unlock,
    output logic       operation_complete,
    output logic       op_aborted,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACTIVE, SEEK_WAIT, REPORT} state_t;

    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(SEEK_TIMEOUT_CYCLES - 1);

    state_t           state, state_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic             is_write, is_write_d;
    logic             pll_seen, pll_seen_d;     // lock observed high during this op
    logic             pll_fired, pll_fired_d;   // unlock already reported this op
    logic             wf_fired, wf_fired_d;     // write fault already reported this op
    logic             pll_prev, fault_prev;     // previous-cycle samples for edge detect

    logic crc_data_d, crc_addr_d, missing_am_d, missing_dam_d;
    logic overrun_d, underrun_d, seek_d, write_fault_d, pll_unlock_d;
    logic op_complete_d, op_aborted_d, busy_d;

    // Status bits used by the decode.
    logic st_de, st_or, st_ma, st_dd, st_md, st_ec;
    assign st_de = st1[5];
    assign st_or = st1[4];
    assign st_ma = st1[0];
    assign st_dd = st2[5];
    assign st_md = st2[0];
    assign st_ec = st0[4];

    // Remaining status bits carry no error class tracked here.
    logic unused_status;
    assign unused_status = ^{st0[7:5], st0[3:0], st1[7:6], st1[3:1], st2[7:6], st2[4:1]};

    // The result bytes are decoded at the cmd_done edge and the decoded
    // strobes are what gets stored, so they are visible during REPORT,
    // exactly one cycle after cmd_done.
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so
        // no path leaves one unassigned and no latch is inferred.
        state_d       = state;
        timer_d       = timer;
        is_write_d    = is_write;
        pll_seen_d    = pll_seen;
        pll_fired_d   = pll_fired;
        wf_fired_d    = wf_fired;
        crc_data_d    = 1'b0;
        crc_addr_d    = 1'b0;
        missing_am_d  = 1'b0;
        missing_dam_d = 1'b0;
        overrun_d     = 1'b0;
        underrun_d    = 1'b0;
        seek_d        = 1'b0;
        write_fault_d = 1'b0;
        pll_unlock_d  = 1'b0;
        op_complete_d = 1'b0;
        op_aborted_d  = 1'b0;

        if (cmd_start && state != REPORT) begin
            // A new command pre-empts any op in flight; nothing from the old
            // op is reported.
            op_aborted_d = (state != IDLE);
            timer_d      = '0;
            is_write_d   = cmd_is_write;
            pll_seen_d   = 1'b0;
            pll_fired_d  = 1'b0;
            wf_fired_d   = 1'b0;
            state_d      = cmd_is_seek ? SEEK_WAIT : ACTIVE;
        end else begin
            case (state)
                ACTIVE: begin
                    if (pll_locked)
                        pll_seen_d = 1'b1;
                    if (pll_seen && pll_prev && !pll_locked && !pll_fired) begin
                        pll_unlock_d = 1'b1;
                        pll_fired_d  = 1'b1;
                    end
                    if (is_write && !fault_prev && drive_fault && !wf_fired) begin
                        write_fault_d = 1'b1;
                        wf_fired_d    = 1'b1;
                    end
                    if (cmd_done) begin
                        crc_data_d    = st_de & st_dd;
                        crc_addr_d    = st_de & ~st_dd;
                        missing_dam_d = st_ma & st_md;
                        missing_am_d  = st_ma & ~st_md;
                        overrun_d     = st_or & ~is_write;
                        underrun_d    = st_or & is_write;
                        seek_d        = st_ec;
                        op_complete_d = 1'b1;
                        state_d       = REPORT;
                    end
                end
                SEEK_WAIT: begin
                    if (seek_complete) begin
                        state_d = IDLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        seek_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            timer              <= '0;
            is_write           <= 1'b0;
            pll_seen           <= 1'b0;
            pll_fired          <= 1'b0;
            wf_fired           <= 1'b0;
            pll_prev           <= 1'b0;
            fault_prev         <= 1'b0;
            err_crc_data       <= 1'b0;
            err_crc_addr       <= 1'b0;
            err_missing_am     <= 1'b0;
            err_missing_dam    <= 1'b0;
            err_overrun        <= 1'b0;
            err_underrun       <= 1'b0;
            err_seek           <= 1'b0;
            err_write_fault    <= 1'b0;
            err_pll_unlock     <= 1'b0;
            operation_complete <= 1'b0;
            op_aborted         <= 1'b0;
            busy               <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating
            // from the same pre-edge values, independent of statement order.
            state              <= state_d;
            timer              <= timer_d;
            is_write           <= is_write_d;
            pll_seen           <= pll_seen_d;
            pll_fired          <= pll_fired_d;
            wf_fired           <= wf_fired_d;
            pll_prev           <= pll_locked;
            fault_prev         <= drive_fault;
            err_crc_data       <= crc_data_d;
            err_crc_addr       <= crc_addr_d;
            err_missing_am     <= missing_am_d;
            err_missing_dam    <= missing_dam_d;
            err_overrun        <= overrun_d;
            err_underrun       <= underrun_d;
            err_seek           <= seek_d;
            err_write_fault    <= write_fault_d;
            err_pll_unlock     <= pll_unlock_d;
            operation_complete <= op_complete_d;
            op_aborted         <= op_aborted_d;
            busy               <= busy_d;
        end
    end

endmodule

// File: tb/tb_fdc_error_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_fdc_error_event_decoder
//
// Directed bench for fdc_error_event_decoder with a 100-cycle seek timeout.
// The twelve outputs are packed into one vector, observed on the falling
// edge:
//   [11] crc_data [10] crc_addr [9] missing_am [8] missing_dam
//   [7] overrun [6] underrun [5] seek [4] write_fault [3] pll_unlock
//   [2] operation_complete [1] op_aborted [0] busy
// ---------------------------------------------------------------------------
module tb_fdc_error_event_decoder;

    localparam int unsigned TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_start, cmd_is_seek, cmd_is_write, cmd_done;
    logic [7:0] st0, st1, st2;
    logic       seek_complete, pll_locked, drive_fault;
    logic       err_crc_data, err_crc_addr, err_missing_am, err_missing_dam;
    logic       err_overrun, err_underrun, err_seek, err_write_fault, err_pll_unlock;
    logic       operation_complete, op_aborted, busy;

    int total = 0;
    int bad   = 0;

    fdc_error_event_decoder #(
        .SEEK_TIMEOUT_CYCLES(TIMEOUT),
        .TMR_W              (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_start         (cmd_start),
        .cmd_is_seek       (cmd_is_seek),
        .cmd_is_write      (cmd_is_write),
        .cmd_done          (cmd_done),
        .st0               (st0),
        .st1               (st1),
        .st2               (st2),
        .seek_complete     (seek_complete),
        .pll_locked        (pll_locked),
        .drive_fault       (drive_fault),
        .err_crc_data      (err_crc_data),
        .err_crc_addr      (err_crc_addr),
        .err_missing_am    (err_missing_am),
        .err_missing_dam   (err_missing_dam),
        .err_overrun       (err_overrun),
        .err_underrun      (err_underrun),
        .err_seek          (err_seek),
        .err_write_fault   (err_write_fault),
        .err_pll_unlock    (err_pll_unlock),
        .operation_complete(operation_complete),
        .op_aborted        (op_aborted),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {err_crc_data, err_crc_addr, err_missing_am, err_missing_dam,
                  err_overrun, err_underrun, err_seek, err_write_fault,
                  err_pll_unlock, operation_complete, op_aborted, busy};

    task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
        total++;
        assert (o === e)
        else begin
            bad++;
            $error("FAIL %s observed=%03h expected=%03h", tag, o, e);
        end
    endtask

    // Inputs are changed at a falling edge; one call spans a rising edge and
    // returns on the next falling edge, where outputs are sampled.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_cmd(input logic seek, input logic wr);
        cmd_start    = 1'b1;
        cmd_is_seek  = seek;
        cmd_is_write = wr;
        cyc();
        cmd_start    = 1'b0;
        cmd_is_seek  = 1'b0;
        cmd_is_write = 1'b0;
    endtask

    task automatic finish_cmd(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        cmd_done = 1'b1;
        st0 = s0;
        st1 = s1;
        st2 = s2;
        cyc();
        cmd_done = 1'b0;
        st0 = 8'h00;
        st1 = 8'h00;
        st2 = 8'h00;
    endtask

    logic [11:0] acc;

    initial begin
        reset = 1'b1;
        cmd_start = 1'b0; cmd_is_seek = 1'b0; cmd_is_write = 1'b0; cmd_done = 1'b0;
        st0 = 8'h00; st1 = 8'h00; st2 = 8'h00;
        seek_complete = 1'b0; pll_locked = 1'b0; drive_fault = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", obs, 12'h000);
        reset = 1'b0;
        cyc();
        check("idle_after_reset", obs, 12'h000);

        // cmd_done in IDLE is ignored
        finish_cmd(8'h10, 8'h20, 8'h20);
        check("idle_cmd_done", obs, 12'h000);

        // Read with data CRC error
        start_cmd(1'b0, 1'b0);
        check("rd_busy", obs, 12'h001);
        cyc();
        finish_cmd(8'h00, 8'h20, 8'h20);
        check("rd_crc_data", obs, 12'h805);
        cyc();
        check("rd_idle", obs, 12'h000);

        // Write with overrun+missing AM bits -> underrun + missing DAM
        start_cmd(1'b0, 1'b1);
        finish_cmd(8'h00, 8'h11, 8'h01);
        check("wr_underrun_dam", obs, 12'h145);
        cyc();

        // Read with overrun + missing AM
        start_cmd(1'b0, 1'b0);
        finish_cmd(8'h00, 8'h11, 8'h00);
        check("rd_overrun_am", obs, 12'h285);
        cyc();

        // Read with EC in ST0
        start_cmd(1'b0, 1'b0);
        finish_cmd(8'h10, 8'h00, 8'h00);
        check("rd_ec", obs, 12'h025);
        cyc();

        // Seek timeout: err_seek appears 100 cycles after the start edge
        start_cmd(1'b1, 1'b0);
        check("seek_busy", obs, 12'h001);
        acc = 12'h000;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            cyc();
            acc = acc | (obs & 12'h020);
        end
        check("seek_no_early", acc, 12'h000);
        check("seek_busy_last", obs, 12'h001);
        cyc();
        check("seek_timeout", obs, 12'h020);
        cyc();
        check("seek_idle", obs, 12'h000);

        // Seek completing normally
        start_cmd(1'b1, 1'b0);
        repeat (5) cyc();
        seek_complete = 1'b1;
        cyc();
        seek_complete = 1'b0;
        check("seek_done", obs, 12'h000);

        // seek_complete on the terminal cycle wins over the timeout
        start_cmd(1'b1, 1'b0);
        for (int i = 1; i < int'(TIMEOUT); i++) cyc();
        seek_complete = 1'b1;
        cyc();
        seek_complete = 1'b0;
        check("seek_terminal_win", obs, 12'h000);
        cyc();

        // PLL toggles 1-0-1-0: exactly one unlock pulse
        start_cmd(1'b0, 1'b0);
        pll_locked = 1'b1;
        cyc();
        check("pll_locked_quiet", obs, 12'h001);
        pll_locked = 1'b0;
        cyc();
        check("pll_unlock_1", obs, 12'h009);
        pll_locked = 1'b1;
        cyc();
        check("pll_relock", obs, 12'h001);
        pll_locked = 1'b0;
        cyc();
        check("pll_unlock_2_none", obs, 12'h001);
        finish_cmd(8'h00, 8'h00, 8'h00);
        check("pll_op_done", obs, 12'h005);
        cyc();

        // Lock never high: no unlock pulse
        start_cmd(1'b0, 1'b0);
        acc = 12'h000;
        repeat (4) begin
            cyc();
            acc = acc | (obs & 12'h008);
        end
        check("pll_never_locked", acc, 12'h000);
        finish_cmd(8'h00, 8'h00, 8'h00);
        check("pll_never_done", obs, 12'h005);
        cyc();

        // Unlock coinciding with cmd_done: both reported together
        start_cmd(1'b0, 1'b0);
        pll_locked = 1'b1;
        cyc();
        pll_locked = 1'b0;
        finish_cmd(8'h00, 8'h20, 8'h00);
        check("pll_with_report", obs, 12'h40D);
        cyc();

        // Write fault: already high at start does not fire; one pulse per op
        drive_fault = 1'b1;
        start_cmd(1'b0, 1'b1);
        cyc();
        check("wf_preexisting", obs, 12'h001);
        drive_fault = 1'b0;
        cyc();
        drive_fault = 1'b1;
        cyc();
        check("wf_edge", obs, 12'h011);
        drive_fault = 1'b0;
        cyc();
        drive_fault = 1'b1;
        cyc();
        check("wf_second_none", obs, 12'h001);
        finish_cmd(8'h00, 8'h00, 8'h00);
        check("wf_done", obs, 12'h005);
        drive_fault = 1'b0;
        cyc();

        // Write fault edge on a read does not fire
        start_cmd(1'b0, 1'b0);
        drive_fault = 1'b1;
        cyc();
        check("wf_on_read", obs, 12'h001);
        drive_fault = 1'b0;
        finish_cmd(8'h00, 8'h00, 8'h00);
        cyc();

        // Abort mid-read, then the new read finishes with an address CRC error
        start_cmd(1'b0, 1'b0);
        cyc();
        start_cmd(1'b0, 1'b0);
        check("abort_pulse", obs, 12'h003);
        cyc();
        check("abort_once", obs, 12'h001);
        finish_cmd(8'h00, 8'h20, 8'h00);
        check("abort_crc_addr", obs, 12'h405);
        cyc();
        check("abort_idle", obs, 12'h000);

        // Abort a seek with a read
        start_cmd(1'b1, 1'b0);
        cyc();
        start_cmd(1'b0, 1'b0);
        check("abort_seek", obs, 12'h003);
        finish_cmd(8'h00, 8'h00, 8'h00);
        check("abort_seek_done", obs, 12'h005);
        cyc();

        // Reset in ACTIVE, then cmd_done: nothing reported
        start_cmd(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_async", obs, 12'h000);
        @(negedge clk);
        finish_cmd(8'h10, 8'h20, 8'h20);
        reset = 1'b0;
        cyc();
        check("reset_held_done", obs, 12'h000);
        finish_cmd(8'h10, 8'h20, 8'h20);
        check("reset_then_done", obs, 12'h000);
        cyc();
        check("reset_final_idle", obs, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
